// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
// Shared types and constants for the input_debouncer block.
//   db_state_e     : per-channel debounce FSM state
//   CLK_HZ         : CLOCK_50 frequency
//   DEBOUNCE_10MS  : cycles in 10 ms at CLK_HZ, default debounce window
//   state_level()  : accepted level implied by an FSM state
// -----------------------------------------------------------------------------
package debounce_pkg;

  // Bit 1 of the encoding is the accepted level; bit 0 marks a pending change.
  typedef enum logic [1:0] {
    STABLE_LO = 2'b00,
    WAIT_HI   = 2'b01,
    STABLE_HI = 2'b10,
    WAIT_LO   = 2'b11
  } db_state_e;

  localparam int unsigned CLK_HZ        = 50_000_000;
  localparam int unsigned DEBOUNCE_10MS = CLK_HZ / 100;

  function automatic logic state_level(input db_state_e s);
    return (s == STABLE_HI) || (s == WAIT_LO);
  endfunction

endpackage

// File: rtl/debounce_ch.sv
// -----------------------------------------------------------------------------
// debounce_ch
// One debounce channel: 2-FF synchroniser, counter-based debounce FSM,
// registered level plus one-cycle rise/fall strobes, optional toggle bit.
//
// Build option: DEBOUNCE_TOGGLE_EN
//   defined   -> toggle_o flips on every rise strobe (reset value 0)
//   undefined -> toggle_o tied to 0, no toggle flop
//
// Ports:
//   clk_i     in   system clock
//   rst_i     in   synchronous reset, active high
//   raw_i     in   asynchronous raw input
//   level_o   out  debounced level (after optional inversion)
//   rise_o    out  one-cycle strobe when level_o goes 0->1
//   fall_o    out  one-cycle strobe when level_o goes 1->0
//   toggle_o  out  push-on/push-off bit
// -----------------------------------------------------------------------------
module debounce_ch
  import debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS,
  parameter bit          INVERT          = 1'b0,
  parameter bit          RESET_LEVEL     = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic toggle_o
);

  localparam int unsigned      CNT_W       = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam db_state_e        RESET_STATE = RESET_LEVEL ? STABLE_HI : STABLE_LO;

  logic             sync1_q;
  logic             sync2_q;
  db_state_e        state_q;
  db_state_e        state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             level_q;
  logic             level_d;
  logic             rise_q;
  logic             rise_d;
  logic             fall_q;
  logic             fall_d;

  // Synchroniser; inversion is applied before the first flop.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= RESET_LEVEL;
      sync2_q <= RESET_LEVEL;
    end else begin
      sync1_q <= raw_i ^ INVERT;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RESET_STATE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // cnt counts consecutive synchronised samples that disagree with the
  // accepted level; it is zero in both stable states.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      STABLE_LO: begin
        if (sync2_q) begin
          state_d = WAIT_HI;
          cnt_d   = CNT_W'(1);
        end
      end
      WAIT_HI: begin
        if (!sync2_q) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STABLE_HI: begin
        if (!sync2_q) begin
          state_d = WAIT_LO;
          cnt_d   = CNT_W'(1);
        end
      end
      WAIT_LO: begin
        if (sync2_q) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = RESET_STATE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output stage registers the level implied by the FSM state, so level and
  // strobes change together one clock after acceptance (2 + DEBOUNCE_CYCLES
  // clocks after the raw edge is first sampled). Reset loads a level that
  // matches the reset state, so no strobe appears on reset entry or exit.
  always_comb begin
    level_d = state_level(state_q);
    rise_d  = level_d & ~level_q;
    fall_d  = ~level_d & level_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      level_q <= RESET_LEVEL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

`ifdef DEBOUNCE_TOGGLE_EN
  logic toggle_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      toggle_q <= 1'b0;
    end else if (rise_d) begin
      toggle_q <= ~toggle_q;
    end
  end

  assign toggle_o = toggle_q;
`else
  assign toggle_o = 1'b0;
`endif

endmodule

// File: rtl/input_debouncer.sv
// -----------------------------------------------------------------------------
// input_debouncer
// Conditions raw board inputs (SW/KEY) into clean levels and one-cycle
// rise/fall strobes in the CLOCK_50 domain. One independent debounce_ch per
// input channel.
//
// Build option: DEBOUNCE_TOGGLE_EN (adds push-on/push-off toggle_out bits;
// toggle_out is constant 0 when undefined).
//
// Ports:
//   CLOCK_50    in   [1]     system clock, 50 MHz
//   rst         in   [1]     synchronous reset, active high
//   raw_in      in   [N_CH]  asynchronous board inputs
//   level_out   out  [N_CH]  debounced level, post-inversion
//   rise_pulse  out  [N_CH]  one-cycle strobe on level_out 0->1
//   fall_pulse  out  [N_CH]  one-cycle strobe on level_out 1->0
//   toggle_out  out  [N_CH]  toggle state per channel
//
// Parameters: N_CH, DEBOUNCE_CYCLES (>= 2), INVERT (per-channel raw
// inversion), RESET_LEVEL (per-channel post-inversion reset level).
// -----------------------------------------------------------------------------
module input_debouncer
  import debounce_pkg::*;
#(
  parameter int unsigned     N_CH            = 4,
  parameter int unsigned     DEBOUNCE_CYCLES = DEBOUNCE_10MS,
  parameter logic [N_CH-1:0] INVERT          = '0,
  parameter logic [N_CH-1:0] RESET_LEVEL     = '0
) (
  input  logic            CLOCK_50,
  input  logic            rst,
  input  logic [N_CH-1:0] raw_in,
  output logic [N_CH-1:0] level_out,
  output logic [N_CH-1:0] rise_pulse,
  output logic [N_CH-1:0] fall_pulse,
  output logic [N_CH-1:0] toggle_out
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .INVERT          (INVERT[i]),
      .RESET_LEVEL     (RESET_LEVEL[i])
    ) u_ch (
      .clk_i    (CLOCK_50),
      .rst_i    (rst),
      .raw_i    (raw_in[i]),
      .level_o  (level_out[i]),
      .rise_o   (rise_pulse[i]),
      .fall_o   (fall_pulse[i]),
      .toggle_o (toggle_out[i])
    );
  end

endmodule

// File: tb/tb_input_debouncer.sv
// -----------------------------------------------------------------------------
// tb_input_debouncer
// Self-checking bench for input_debouncer (N_CH=4, DEBOUNCE_CYCLES=8,
// INVERT=4'b1000, RESET_LEVEL=4'b1000). Honours DEBOUNCE_TOGGLE_EN.
// A run-length reference model is compared every cycle; directed scenarios
// add hand-derived expectations on top.
// -----------------------------------------------------------------------------
module tb_input_debouncer;

  localparam int unsigned NCH = 4;
  localparam int unsigned D   = 8;
  localparam logic [3:0]  INV = 4'b1000;
  localparam logic [3:0]  RL  = 4'b1000;

  logic       CLOCK_50 = 1'b0;
  logic       rst;
  logic [3:0] raw_in;
  logic [3:0] level_out;
  logic [3:0] rise_pulse;
  logic [3:0] fall_pulse;
  logic [3:0] toggle_out;

  always #10 CLOCK_50 = ~CLOCK_50;

  input_debouncer #(
    .N_CH            (NCH),
    .DEBOUNCE_CYCLES (D),
    .INVERT          (INV),
    .RESET_LEVEL     (RL)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .rst        (rst),
    .raw_in     (raw_in),
    .level_out  (level_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .toggle_out (toggle_out)
  );

  // Reference model: a change is accepted once D consecutive synchronised
  // samples (raw delayed by two clocks) disagree with the accepted value; the
  // visible level follows the accepted value one clock later.
  logic [3:0]  p1, p2, acc;
  logic [3:0]  m_level, m_rise, m_fall, m_tog;
  int unsigned run [4];
  bit          started = 1'b0;

  always @(posedge CLOCK_50) begin
    started = 1'b1;
    if (rst) begin
      p1 = RL; p2 = RL; acc = RL;
      m_level = RL; m_rise = '0; m_fall = '0; m_tog = '0;
      for (int unsigned c = 0; c < NCH; c++) run[c] = 0;
    end else begin
      m_rise  = acc & ~m_level;
      m_fall  = ~acc & m_level;
      m_level = acc;
`ifdef DEBOUNCE_TOGGLE_EN
      m_tog   = m_tog ^ m_rise;
`endif
      for (int unsigned c = 0; c < NCH; c++) begin
        if (p2[c] != acc[c]) begin
          run[c] = run[c] + 1;
          if (run[c] == D) begin
            acc[c] = ~acc[c];
            run[c] = 0;
          end
        end else begin
          run[c] = 0;
        end
      end
      p2 = p1;
      p1 = raw_in ^ INV;
    end
  end

  // Directed expectations handed to the compare process.
  logic       pin_en = 1'b0;
  string      pin_name;
  logic [3:0] pin_mask, pin_lvl, pin_rise, pin_fall, pin_tog;

  int unsigned vectors = 0;
  int unsigned errors  = 0;

  always @(negedge CLOCK_50) begin
    if (started) begin
      vectors++;
      if (level_out !== m_level || rise_pulse !== m_rise ||
          fall_pulse !== m_fall || toggle_out !== m_tog) begin
        errors++;
        $display("FAIL model t=%0t got lvl=%b rise=%b fall=%b tog=%b need lvl=%b rise=%b fall=%b tog=%b",
                 $time, level_out, rise_pulse, fall_pulse, toggle_out,
                 m_level, m_rise, m_fall, m_tog);
      end
      if (pin_en) begin
        vectors++;
        if (((level_out ^ pin_lvl) & pin_mask) !== 4'b0000 ||
            ((rise_pulse ^ pin_rise) & pin_mask) !== 4'b0000 ||
            ((fall_pulse ^ pin_fall) & pin_mask) !== 4'b0000 ||
            (toggle_out ^ pin_tog) !== 4'b0000) begin
          errors++;
          $display("FAIL %s t=%0t got lvl=%b rise=%b fall=%b tog=%b need lvl=%b rise=%b fall=%b tog=%b mask=%b",
                   pin_name, $time, level_out, rise_pulse, fall_pulse, toggle_out,
                   pin_lvl, pin_rise, pin_fall, pin_tog, pin_mask);
        end
      end
    end
  end

  logic [3:0] cur;
  logic [3:0] cur_tog;

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
    pin_en = 1'b0;
  endtask

  task automatic pin(input string nm, input logic [3:0] m, input logic [3:0] l,
                     input logic [3:0] r, input logic [3:0] f);
    pin_en   = 1'b1;
    pin_name = nm;
    pin_mask = m;
    pin_lvl  = l;
    pin_rise = r;
    pin_fall = f;
`ifdef DEBOUNCE_TOGGLE_EN
    pin_tog  = cur_tog;
`else
    pin_tog  = 4'b0000;
`endif
  endtask

  // Drive a new post-inversion target and hold it; changed channels must
  // switch exactly D+2 clocks after the first sampling edge (k == 0).
  task automatic settle(input string nm, input logic [3:0] tgt);
    logic [3:0] chg;
    chg    = tgt ^ cur;
    raw_in = tgt ^ INV;
    for (int unsigned k = 0; k < D + 4; k++) begin
      tick();
      if (k == D + 2) begin
        cur_tog = cur_tog ^ (chg & tgt);
        cur     = tgt;
        pin(nm, 4'hF, cur, chg & tgt, chg & ~tgt);
      end else begin
        pin(nm, 4'hF, cur, 4'h0, 4'h0);
      end
    end
  endtask

  // Channel 1 high for w sampling edges then low again.
  task automatic glitch1(input string nm, input int unsigned w);
    logic       takes;
    logic [3:0] lv, r, f;
    takes     = (w >= D);
    raw_in[1] = ~INV[1];
    for (int unsigned k = 0; k < w + D + 4; k++) begin
      tick();
      if (k == w - 1) raw_in[1] = INV[1];
      lv = cur; r = 4'h0; f = 4'h0;
      if (takes && k >= D + 2 && k < w + D + 2) lv[1] = 1'b1;
      if (takes && k == D + 2) begin
        r[1]       = 1'b1;
        cur_tog[1] = ~cur_tog[1];
      end
      if (takes && k == w + D + 2) f[1] = 1'b1;
      pin(nm, 4'hF, lv, r, f);
    end
  endtask

  int unsigned ch;

  initial begin
    rst     = 1'b1;
    raw_in  = 4'b0000;
    cur     = RL;
    cur_tog = 4'b0000;

    for (int unsigned k = 0; k < 3; k++) begin
      tick();
      pin("reset", 4'hF, RL, 4'h0, 4'h0);
    end
    rst = 1'b0;
    settle("idle_after_reset", 4'b1000);

    settle("ch0_rise", 4'b1001);
    glitch1("glitch5", 5);
    glitch1("glitch7", 7);
    glitch1("pulse8", 8);

    settle("key3_release", 4'b0001);
    settle("key3_press", 4'b1001);
    settle("key3_release2", 4'b0001);
    settle("key3_press2", 4'b1001);

    // Reset while channel 2 is five counts into its window.
    raw_in[2] = ~INV[2];
    for (int unsigned k = 0; k < 7; k++) begin
      tick();
      pin("rst_mid_wait", 4'hF, cur, 4'h0, 4'h0);
    end
    rst = 1'b1;
    tick();
    cur     = RL;
    cur_tog = 4'b0000;
    pin("rst_mid_apply", 4'hF, cur, 4'h0, 4'h0);
    rst = 1'b0;
    settle("rst_mid_reaccept", 4'b1101);

    settle("fall_02", 4'b1000);
    settle("rise_01", 4'b1011);

    for (int unsigned n = 0; n < 3000; n++) begin
      tick();
      rst = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 7) == 0) begin
        ch         = $urandom_range(0, 3);
        raw_in[ch] = ~raw_in[ch];
      end
    end
    rst = 1'b0;
    for (int unsigned k = 0; k < 4; k++) tick();

    @(negedge CLOCK_50);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
